// File: rtl/risc_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes,
// controller state encoding and the access-legality decode.
package risc_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ST_RD = 3'd2,
    ST_WR = 3'd3,
    RESP  = 3'd4
  } lsu_state_e;

  // Width/sign code not valid for the direction, or address not naturally aligned.
  function automatic logic access_illegal(input logic store, input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (store) begin
      if (funct3[2] || (funct3 == 3'b011)) bad = 1'b1;
    end else begin
      if ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)) bad = 1'b1;
    end
    if (!bad) begin
      if ((funct3[1:0] == 2'b01) && off[0]) bad = 1'b1;
      if ((funct3[1:0] == 2'b10) && (off != 2'b00)) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/risc_lsu_32_if.sv
// Core-side request/response bus of the load/store unit.
// master = core (initiator of requests), slave = LSU.
interface risc_lsu_32_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/risc_lsu_align.sv
// Combinational data path of the LSU: load lane extract/extend and
// store lane merge for read-modify-write of sub-word stores.
module risc_lsu_align
  import risc_lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte/halfword lane and extend it by funct3.
  always_comb begin
    sel_byte = 8'h00;
    case (off)
      2'd0: sel_byte = rd_word[7:0];
      2'd1: sel_byte = rd_word[15:8];
      2'd2: sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = off[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'h000000, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'h0000, sel_half};
      default: load_data = rd_word;
    endcase
  end

  // Replace the addressed lane(s) of the old word with the store data.
  always_comb begin
    store_word = rd_word;
    case (funct3)
      F3_B:    store_word[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H:    store_word[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/risc_lsu_32.sv
// Load/store unit: turns byte/half/word loads and stores into whole-word
// accesses on a synchronous-write / asynchronous-read data memory.
// Optional macro RISC_LSU_RANGE_CHECK_EN: word index >= MEM_WORDS is illegal.
module risc_lsu_32
  import risc_lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic               clk,
  input  logic               areset,
  risc_lsu_32_if.slave       core,
  output logic [31:0]        mem_addr_32,
  output logic               mem_we,
  output logic [31:0]        mem_wdata_32,
  input  logic [31:0]        mem_rdata_32
);

  lsu_state_e  state_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;
  logic [31:0] wdata_reg;
  logic        req_ready_reg;
  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic [31:0] resp_rdata_reg;
  logic [31:0] mem_addr_reg;
  logic        mem_we_reg;
  logic [31:0] mem_wdata_reg;

  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        range_bad;
  logic        req_illegal;

  risc_lsu_align u_align (
    .rd_word    (mem_rdata_32),
    .wdata      (wdata_reg),
    .off        (off_reg),
    .funct3     (funct3_reg),
    .load_data  (load_data),
    .store_word (store_word)
  );

`ifdef RISC_LSU_RANGE_CHECK_EN
  logic [31:0] word_idx;
  assign word_idx  = {2'b00, core.req_addr[31:2]};
  assign range_bad = (word_idx >= 32'(MEM_WORDS));
`else
  assign range_bad = 1'b0;
`endif

  assign req_illegal = access_illegal(core.req_store, core.req_funct3, core.req_addr[1:0])
                       | range_bad;

  // Controller: every output is a register updated on the transition into its state.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_reg      <= IDLE;
      funct3_reg     <= 3'b000;
      off_reg        <= 2'b00;
      wdata_reg      <= 32'h0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'h0;
      mem_addr_reg   <= 32'h0;
      mem_we_reg     <= 1'b0;
      mem_wdata_reg  <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (core.req_valid) begin
            funct3_reg    <= core.req_funct3;
            off_reg       <= core.req_addr[1:0];
            wdata_reg     <= core.req_wdata;
            req_ready_reg <= 1'b0;
            if (req_illegal) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= 32'h0;
            end else if (!core.req_store) begin
              state_reg    <= LOAD;
              mem_addr_reg <= {core.req_addr[31:2], 2'b00};
            end else if (core.req_funct3 == F3_W) begin
              state_reg     <= ST_WR;
              mem_addr_reg  <= {core.req_addr[31:2], 2'b00};
              mem_we_reg    <= 1'b1;
              mem_wdata_reg <= core.req_wdata;
            end else begin
              state_reg    <= ST_RD;
              mem_addr_reg <= {core.req_addr[31:2], 2'b00};
            end
          end
        end
        LOAD: begin
          state_reg      <= RESP;
          resp_valid_reg <= 1'b1;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= load_data;
          mem_addr_reg   <= 32'h0;
        end
        ST_RD: begin
          // Old word is merged here so the write cycle only has to present it.
          state_reg     <= ST_WR;
          mem_we_reg    <= 1'b1;
          mem_wdata_reg <= store_word;
        end
        ST_WR: begin
          state_reg      <= RESP;
          mem_we_reg     <= 1'b0;
          mem_wdata_reg  <= 32'h0;
          mem_addr_reg   <= 32'h0;
          resp_valid_reg <= 1'b1;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= 32'h0;
        end
        RESP: begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b0;
          resp_err_reg   <= 1'b0;
          req_ready_reg  <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign core.req_ready  = req_ready_reg;
  assign core.resp_valid = resp_valid_reg;
  assign core.resp_err   = resp_err_reg;
  assign core.resp_rdata = resp_rdata_reg;
  assign mem_addr_32     = mem_addr_reg;
  assign mem_we          = mem_we_reg;
  assign mem_wdata_32    = mem_wdata_reg;

endmodule

// File: tb/tb_risc_lsu_32.sv
// Scoreboard bench for risc_lsu_32: driver pushes expected responses from a
// byte-lane reference model, a monitor pops and compares on each resp_valid.
`timescale 1ns/1ps
module tb_risc_lsu_32;

  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  risc_lsu_32_if core ();
  logic [31:0] mem_addr_32;
  logic        mem_we;
  logic [31:0] mem_wdata_32;
  logic [31:0] mem_rdata_32;

  risc_lsu_32 #(.MEM_WORDS(64)) dut (
    .clk          (clk),
    .areset       (areset),
    .core         (core),
    .mem_addr_32  (mem_addr_32),
    .mem_we       (mem_we),
    .mem_wdata_32 (mem_wdata_32),
    .mem_rdata_32 (mem_rdata_32)
  );

  // Data memory: synchronous write, asynchronous read valid only while we=0.
  logic [31:0] mem [64];
  always @(posedge clk) if (mem_we) mem[mem_addr_32[7:2]] <= mem_wdata_32;
  assign mem_rdata_32 = mem_we ? 32'h0 : mem[mem_addr_32[7:2]];

  logic [31:0] ref_mem [64];

  typedef struct {
    int          id;
    bit          err;
    bit [31:0]   rdata;
    int          lat;
    int          writes;
    int          acc_cyc;
  } exp_t;
  exp_t sbq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int next_id = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // Reference model: memory as bytes, sizes and lanes from the ISA rules.
  task automatic model(input bit st, input bit [2:0] f3, input bit [31:0] a,
                       input bit [31:0] wd, output exp_t e);
    bit        legal;
    int        size;
    int        idx;
    int        sh;
    bit [31:0] mask;
    bit [31:0] v;
    idx = int'(a[7:2]);
    sh = 8 * int'(a[1:0]);
    if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (legal && ((a % size) != 0)) legal = 0;
`ifdef RISC_LSU_RANGE_CHECK_EN
    if ((a / 4) >= 64) legal = 0;
`endif
    mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    e.err = 0; e.rdata = 0; e.writes = 0; e.lat = 2;
    if (!legal) begin
      e.err = 1; e.lat = 1;
    end else if (st) begin
      ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
      e.writes = 1;
      e.lat = (size == 4) ? 2 : 3;
    end else begin
      v = (ref_mem[idx] >> sh) & mask;
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
      e.rdata = v;
    end
  endtask

  task automatic issue(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
    exp_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (!core.req_ready && t < 50) begin @(negedge clk); t++; end
    if (!core.req_ready) begin
      tests++; fails++;
      $display("FAIL req_ready_timeout: got 0 required 1");
      return;
    end
    core.req_valid = 1; core.req_store = st; core.req_funct3 = f3;
    core.req_addr = a; core.req_wdata = wd;
    model(st, f3, a, wd, e);
    e.id = next_id++;
    @(posedge clk); #1;
    e.acc_cyc = cyc;
    sbq.push_back(e);
    core.req_valid = 0;
  endtask

  // Monitor: compare each response pulse against the oldest expectation.
  int we_cnt = 0;
  logic [31:0] last_rdata = 32'h0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!areset) begin
        we_cnt = 0; last_rdata = 32'h0;
      end else begin
        if (mem_we) we_cnt++;
        if (core.resp_valid) begin
          if (sbq.size() == 0) begin
            tests++; fails++;
            $display("FAIL resp_unexpected: got resp_valid 1 required 0");
          end else begin
            e = sbq.pop_front();
            chk("resp_err", {31'h0, core.resp_err}, {31'h0, e.err});
            chk("resp_rdata", core.resp_rdata, e.rdata);
            chk("latency", cyc - e.acc_cyc + 1, e.lat);
            chk("mem_writes", we_cnt, e.writes);
            $display("[TB] txn %0d err=%0d rdata=%h lat=%0d", e.id, core.resp_err,
                     core.resp_rdata, cyc - e.acc_cyc + 1);
          end
          we_cnt = 0;
          last_rdata = core.resp_rdata;
        end else begin
          chk("rdata_hold", core.resp_rdata, last_rdata);
        end
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin @(negedge clk); t++; end
    if (sbq.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending required 0", sbq.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    bit [31:0] a;
    core.req_valid = 0; core.req_store = 0; core.req_funct3 = 0;
    core.req_addr = 0; core.req_wdata = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'h0, core.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, core.resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, core.resp_err}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_resp_rdata", core.resp_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr_32, 32'h0);
    chk("rst_mem_wdata", mem_wdata_32, 32'h0);
    areset = 1;

    // Directed: SW/LW, read-modify-write SB, sub-word loads
    issue(1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(0, 3'b010, 32'h10, 32'h0);
    issue(1, 3'b010, 32'h10, 32'h11223344);
    issue(1, 3'b000, 32'h13, 32'h000000AA);
    issue(0, 3'b010, 32'h10, 32'h0);
    issue(0, 3'b000, 32'h13, 32'h0);
    issue(0, 3'b100, 32'h13, 32'h0);
    issue(0, 3'b001, 32'h12, 32'h0);
    // Illegal accesses
    issue(0, 3'b010, 32'h12, 32'h0);
    issue(1, 3'b001, 32'h11, 32'h1234);
    issue(0, 3'b011, 32'h20, 32'h0);
    // Word 64: range-checked or passed straight through
    issue(0, 3'b010, 32'h100, 32'h0);
    @(negedge clk);
`ifdef RISC_LSU_RANGE_CHECK_EN
    chk("range_mem_addr", mem_addr_32, 32'h0);
`else
    chk("range_mem_addr", mem_addr_32, 32'h100);
`endif
    // Top of address space
    issue(1, 3'b010, 32'hFFFF_FFFC, 32'hCAFEF00D);
    issue(0, 3'b010, 32'hFFFF_FFFC, 32'h0);
    drain();

    // Reset asserted while an SB is in its write cycle
    core.req_valid = 1; core.req_store = 1; core.req_funct3 = 3'b000;
    core.req_addr = 32'h21; core.req_wdata = 32'h55;
    @(posedge clk); #1;
    core.req_valid = 0;
    t = 0;
    @(negedge clk);
    while (!mem_we && t < 10) begin @(negedge clk); t++; end
    chk("midsb_reached_wr", {31'h0, mem_we}, 32'h1);
    areset = 0;
    #1;
    chk("midsb_mem_we", {31'h0, mem_we}, 32'h0);
    chk("midsb_req_ready", {31'h0, core.req_ready}, 32'h1);
    chk("midsb_resp_valid", {31'h0, core.resp_valid}, 32'h0);
    chk("midsb_mem_addr", mem_addr_32, 32'h0);
    chk("midsb_mem_wdata", mem_wdata_32, 32'h0);
    chk("midsb_resp_rdata", core.resp_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    areset = 1;
    chk("midsb_mem_word", mem[8], ref_mem[8]);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
        default: a = 32'($urandom_range(0, 255));
      endcase
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    drain();

    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
